// File: rtl/si5340_i2c_responder_pkg.sv
// Shared definitions for the Si5340 I2C responder.
// Holds the default target address, byte width, glitch-filter tap count,
// the r_w bit encoding and the responder FSM state type.
package si5340_i2c_responder_pkg;

    localparam logic [6:0] SLAVE_ADDR    = 7'b111_0100;
    localparam int         DATA_WIDTH    = 8;
    localparam int         I2C_FILT_TAPS = 3;

    typedef enum logic {
        RW_WRITE = 1'b0,
        RW_READ  = 1'b1
    } r_w_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_REG,
        ST_REG_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } state_e;

endpackage

// File: rtl/si5340_i2c_responder_i2c_line_cond.sv
// I2C line conditioner: 2-FF synchronizer, optional 3-tap majority glitch
// filter (enabled by defining I2C_GLITCH_FILTER_EN), and rise/fall flags.
// Ports:
//   clk_i, rst_i   system clock, synchronous active-high reset
//   line_i         asynchronous SCL or SDA input
//   level_o        conditioned line level
//   rise_o/fall_o  one-cycle edge flags of level_o
module i2c_line_cond
    import si5340_i2c_responder_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync;
    logic       filt;
    logic       prev;

    // Reset to the idle-high bus level so no edge is flagged out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) sync <= '1;
        else       sync <= {sync[0], line_i};
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [I2C_FILT_TAPS-1:0] taps;

    // A pulse shorter than 2 clk only ever occupies one tap and loses the vote.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            taps <= '1;
            filt <= 1'b1;
        end else begin
            taps <= {taps[I2C_FILT_TAPS-2:0], sync[1]};
            filt <= (taps[0] & taps[1]) | (taps[0] & taps[2]) | (taps[1] & taps[2]);
        end
    end
`else
    assign filt = sync[1];
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) prev <= 1'b1;
        else       prev <= filt;
    end

    assign level_o = filt;
    assign rise_o  = filt & ~prev;
    assign fall_o  = ~filt & prev;

endmodule

// File: rtl/si5340_i2c_responder.sv
// Si5340 register-interface I2C target. Decodes START/STOP, address,
// register and data bytes, forwards writes and read requests to a 16-bit
// {page,reg} register space. Optional input glitch filter: I2C_GLITCH_FILTER_EN.
// Ports:
//   clk_i, rst_i        system clock, synchronous active-high reset
//   scl_i, sda_i        asynchronous I2C lines
//   sda_oe_o            1 = pull SDA low
//   wr_valid_o/addr/data  one-cycle write strobe with {page,reg} and data
//   rd_req_o/rd_addr_o  one-cycle read request with {page,reg}
//   rd_data_i           read data, valid RD_LAT cycles after rd_req_o
//   busy_o              1 from START until STOP
module si5340_i2c_responder
    import si5340_i2c_responder_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = SLAVE_ADDR,
    parameter int         DATA_WIDTH = si5340_i2c_responder_pkg::DATA_WIDTH,
    parameter logic [7:0] PAGE_REG   = 8'h01,
    parameter int         RD_LAT     = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      sda_oe_o,
    output logic                      wr_valid_o,
    output logic [2*DATA_WIDTH-1:0]   wr_addr_o,
    output logic [DATA_WIDTH-1:0]     wr_data_o,
    output logic                      rd_req_o,
    output logic [2*DATA_WIDTH-1:0]   rd_addr_o,
    input  logic [DATA_WIDTH-1:0]     rd_data_i,
    output logic                      busy_o
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam int LW = $clog2(RD_LAT + 1);

    logic scl, scl_rise, scl_fall;
    logic sda, sda_rise, sda_fall;

    i2c_line_cond u_scl (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .line_i (scl_i),
        .level_o(scl),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_line_cond u_sda (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .line_i (sda_i),
        .level_o(sda),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    state_e                  state;
    r_w_e                    rw;
    logic [CW-1:0]           cnt;
    logic [DATA_WIDTH-1:0]   sh;
    logic [DATA_WIDTH-1:0]   page;
    logic [DATA_WIDTH-1:0]   reg_idx;
    logic [LW-1:0]           lat;
    logic [DATA_WIDTH-1:0]   byte_in;
    logic                    last_bit;
    logic                    start_c;
    logic                    stop_c;

    assign start_c  = sda_fall & scl;
    assign stop_c   = sda_rise & scl;
    assign byte_in  = {sh[DATA_WIDTH-2:0], sda};
    assign last_bit = (cnt == CW'(DATA_WIDTH - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            rw         <= RW_WRITE;
            cnt        <= '0;
            sh         <= '0;
            page       <= '0;
            reg_idx    <= '0;
            lat        <= '0;
            sda_oe_o   <= 1'b0;
            wr_valid_o <= 1'b0;
            wr_addr_o  <= '0;
            wr_data_o  <= '0;
            rd_req_o   <= 1'b0;
            rd_addr_o  <= '0;
            busy_o     <= 1'b0;
        end else begin
            wr_valid_o <= 1'b0;
            rd_req_o   <= 1'b0;
            if (stop_c) begin
                state    <= ST_IDLE;
                sda_oe_o <= 1'b0;
                busy_o   <= 1'b0;
            end else if (start_c) begin
                state    <= ST_ADDR;
                cnt      <= '0;
                lat      <= '0;
                sda_oe_o <= 1'b0;
                busy_o   <= 1'b1;
            end else begin
                case (state)
                    ST_ADDR, ST_REG, ST_WDATA: begin
                        if (scl_rise) begin
                            sh  <= byte_in;
                            cnt <= cnt + 1'b1;
                            if (last_bit) begin
                                cnt <= '0;
                                if (state == ST_ADDR) begin
                                    if (byte_in[7:1] == DEV_ADDR) begin
                                        rw    <= r_w_e'(byte_in[0]);
                                        state <= ST_ADDR_ACK;
                                    end else begin
                                        state <= ST_IGNORE;
                                    end
                                end else if (state == ST_REG) begin
                                    reg_idx <= byte_in;
                                    state   <= ST_REG_ACK;
                                end else begin
                                    wr_valid_o <= 1'b1;
                                    wr_addr_o  <= {page, reg_idx};
                                    wr_data_o  <= byte_in;
                                    if (reg_idx == PAGE_REG) page <= byte_in;
                                    reg_idx <= reg_idx + 1'b1;
                                    state   <= ST_WDATA_ACK;
                                end
                            end
                        end
                    end
                    // First scl fall starts the ACK bit, second one ends it.
                    ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe_o) begin
                                sda_oe_o <= 1'b1;
                            end else begin
                                sda_oe_o <= 1'b0;
                                cnt      <= '0;
                                if (state == ST_ADDR_ACK && rw == RW_READ) begin
                                    state     <= ST_RDATA;
                                    rd_req_o  <= 1'b1;
                                    rd_addr_o <= {page, reg_idx};
                                    lat       <= LW'(RD_LAT);
                                end else if (state == ST_ADDR_ACK) begin
                                    state <= ST_REG;
                                end else begin
                                    state <= ST_WDATA;
                                end
                            end
                        end
                    end
                    // Waiting on read latency, then the MSB goes out immediately
                    // since the scl fall that would normally drive it has passed.
                    ST_RDATA: begin
                        if (lat != '0) begin
                            lat <= lat - 1'b1;
                            if (lat == LW'(1)) begin
                                sh       <= rd_data_i;
                                sda_oe_o <= ~rd_data_i[DATA_WIDTH-1];
                                cnt      <= '0;
                            end
                        end else if (scl_fall) begin
                            if (last_bit) begin
                                sda_oe_o <= 1'b0;
                                state    <= ST_RDATA_ACK;
                            end else begin
                                cnt      <= cnt + 1'b1;
                                sh       <= {sh[DATA_WIDTH-2:0], 1'b0};
                                sda_oe_o <= ~sh[DATA_WIDTH-2];
                            end
                        end
                    end
                    ST_RDATA_ACK: begin
                        if (scl_rise) begin
                            if (sda) state   <= ST_IGNORE;
                            else     reg_idx <= reg_idx + 1'b1;
                        end else if (scl_fall) begin
                            state     <= ST_RDATA;
                            rd_req_o  <= 1'b1;
                            rd_addr_o <= {page, reg_idx};
                            lat       <= LW'(RD_LAT);
                            cnt       <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
